// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the
// core load/store path (0) and the loader (1), one access at a time.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] be0,
  input  logic [DATA_W/8-1:0] be1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata0,
  output logic [DATA_W-1:0]   rdata1,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     state;
  logic       last_owner;
  logic [2:0] cnt;
  logic       win;

  always_comb begin
    win = 1'b0;
    if (FIXED_PRIO != 0)
      win = ~req0;
    else if (req0 && req1)
      win = ~last_owner;
    else
      win = req1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            owner      <= win;
            last_owner <= win;
            gnt0       <= ~win;
            gnt1       <= win;
            mem_en     <= 1'b1;
            mem_we     <= win ? we1 : we0;
            mem_addr   <= win ? addr1 : addr0;
            mem_wdata  <= win ? wdata1 : wdata0;
            mem_be     <= win ? be1 : be0;
          end
        end
        ISSUE: begin
          // mem_we still holds the issued command's direction here
          if (mem_we) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
            cnt   <= 3'd1;
          end
        end
        WAIT: begin
          if (cnt == LAT) begin
            state <= RESP;
            if (owner) begin
              rdata1  <= mem_rdata;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_rdata;
              rvalid0 <= 1'b1;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: two arbiters (RR/lat1, fixed/lat3) checked
// every cycle against a transaction-level model plus literal pins.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0[2], req1[2], we0[2], we1[2];
  logic [31:0] addr0[2], addr1[2], wdata0[2], wdata1[2];
  logic [3:0]  be0[2], be1[2];
  logic        gnt0[2], gnt1[2], rvalid0[2], rvalid1[2];
  logic [31:0] rdata0[2], rdata1[2];
  logic        mem_en[2], mem_we[2], busy[2], owner[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic [3:0]  mem_be[2];

  dmem_port_arbiter #(.RD_LAT(1), .FIXED_PRIO(0)) u0 (
    .clk(clk), .reset(reset),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]),
    .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .be0(be0[0]), .be1(be1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]),
    .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .rdata0(rdata0[0]), .rdata1(rdata1[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_be(mem_be[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  dmem_port_arbiter #(.RD_LAT(3), .FIXED_PRIO(1)) u1 (
    .clk(clk), .reset(reset),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]),
    .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .be0(be0[1]), .be1(be1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]),
    .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .rdata0(rdata0[1]), .rdata1(rdata1[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_be(mem_be[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_n = 0;
  int pass_n = 0;

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s dut%0d cyc %0d: got %h want %h",
                  nm, d, cyc, act, exp);
  endtask

  function automatic int rdl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  // memories: bench responder (bmem) and model's own copy (mmem)
  logic [31:0] bmem[2][64];
  logic [31:0] mmem[2][64];
  int          rd_c[2] = '{-1, -1};
  logic [31:0] rd_d[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d]) begin
        if (mem_we[d]) begin
          bmem[d][mem_addr[d][7:2]] =
            merge(bmem[d][mem_addr[d][7:2]], mem_wdata[d], mem_be[d]);
        end else begin
          rd_c[d] = cyc + rdl(d);
          rd_d[d] = bmem[d][mem_addr[d][7:2]];
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (cyc == rd_c[d]) ? rd_d[d] : (32'hBAD0_0000 ^ cyc);
  end

  // transaction-level model: when each event must occur, by cycle number
  int          gnt_c[2], resp_c[2], free_c[2];
  logic        who[2], owner_m[2], last_m[2], cmd_we[2];
  logic [31:0] cmd_a[2], cmd_d[2], resp_d[2], held0[2], held1[2];
  logic [3:0]  cmd_b[2];
  logic        ge, mw;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        gnt_c[d] = -100; resp_c[d] = -100; free_c[d] = 0;
        held0[d] = '0; held1[d] = '0;
        owner_m[d] = 1'b0; last_m[d] = 1'b1; who[d] = 1'b0;
        chk("rst_gnt0", d, gnt0[d], 0);
        chk("rst_gnt1", d, gnt1[d], 0);
        chk("rst_rvalid0", d, rvalid0[d], 0);
        chk("rst_rvalid1", d, rvalid1[d], 0);
        chk("rst_rdata0", d, rdata0[d], 0);
        chk("rst_rdata1", d, rdata1[d], 0);
        chk("rst_mem_en", d, mem_en[d], 0);
        chk("rst_mem_we", d, mem_we[d], 0);
        chk("rst_mem_addr", d, mem_addr[d], 0);
        chk("rst_mem_wdata", d, mem_wdata[d], 0);
        chk("rst_mem_be", d, mem_be[d], 0);
        chk("rst_busy", d, busy[d], 0);
        chk("rst_owner", d, owner[d], 0);
      end else begin
        if (cyc == resp_c[d]) begin
          if (who[d]) held1[d] = resp_d[d];
          else held0[d] = resp_d[d];
        end
        ge = (cyc == gnt_c[d]);
        chk("gnt0", d, gnt0[d], ge && !who[d]);
        chk("gnt1", d, gnt1[d], ge && who[d]);
        chk("mem_en", d, mem_en[d], ge);
        if (ge) begin
          chk("mem_we", d, mem_we[d], cmd_we[d]);
          chk("mem_addr", d, mem_addr[d], cmd_a[d]);
          chk("mem_wdata", d, mem_wdata[d], cmd_d[d]);
          chk("mem_be", d, mem_be[d], cmd_b[d]);
        end
        chk("rvalid0", d, rvalid0[d], cyc == resp_c[d] && !who[d]);
        chk("rvalid1", d, rvalid1[d], cyc == resp_c[d] && who[d]);
        chk("rdata0", d, rdata0[d], held0[d]);
        chk("rdata1", d, rdata1[d], held1[d]);
        chk("busy", d, busy[d], cyc >= gnt_c[d] && cyc < free_c[d]);
        chk("owner", d, owner[d], owner_m[d]);
        if (cyc >= free_c[d] && (req0[d] || req1[d])) begin
          if (d == 1) mw = !req0[d];
          else if (req0[d] && req1[d]) mw = !last_m[d];
          else mw = req1[d];
          who[d] = mw; last_m[d] = mw; owner_m[d] = mw;
          gnt_c[d] = cyc + 1;
          cmd_we[d] = mw ? we1[d] : we0[d];
          cmd_a[d] = mw ? addr1[d] : addr0[d];
          cmd_d[d] = mw ? wdata1[d] : wdata0[d];
          cmd_b[d] = mw ? be1[d] : be0[d];
          if (cmd_we[d]) begin
            mmem[d][cmd_a[d][7:2]] =
              merge(mmem[d][cmd_a[d][7:2]], cmd_d[d], cmd_b[d]);
            free_c[d] = cyc + 2;
            resp_c[d] = -100;
          end else begin
            resp_d[d] = mmem[d][cmd_a[d][7:2]];
            resp_c[d] = cyc + 2 + rdl(d);
            free_c[d] = cyc + 3 + rdl(d);
          end
        end
      end
    end
  end

  task automatic set_req(input int d, input int p, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    if (p == 0) begin
      req0[d] = 1'b1; we0[d] = we; addr0[d] = a;
      wdata0[d] = wd; be0[d] = be;
    end else begin
      req1[d] = 1'b1; we1[d] = we; addr1[d] = a;
      wdata1[d] = wd; be1[d] = be;
    end
  endtask

  task automatic drop(input int d, input int p);
    if (p == 0) req0[d] = 1'b0;
    else req1[d] = 1'b0;
  endtask

  task automatic wait_gnt(input int d, input int p, output int g);
    g = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0[d] : gnt1[d]) begin
        g = cyc;
        break;
      end
    end
    chk("gnt_seen", d, g >= 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rv(input int d, input int p, output int r);
    r = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p == 0) ? rvalid0[d] : rvalid1[d]) begin
        r = cyc;
        break;
      end
    end
    chk("rvalid_seen", d, r >= 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic txn(input int d, input int p, input logic we,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output int n, output int g);
    set_req(d, p, we, a, wd, be);
    n = cyc;
    wait_gnt(d, p, g);
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  int glog[$];

  task automatic agent(input int d, input int p);
    int n_l, g_l;
    for (int k = 0; k < 3; k++) begin
      txn(d, p, 1'b0, (p == 0) ? 32'h0 + 32'(4*k) : 32'h20 + 32'(4*k),
          32'h0, 4'h0, n_l, g_l);
      glog.push_back(p);
    end
    drop(d, p);
  endtask

  logic [31:0] wd_t[3] = '{32'hCAFE_0000, 32'h0BAD_F00D, 32'h3333_3333};
  logic [3:0]  be_t[3] = '{4'hF, 4'h0, 4'h5};
  int n, g, r, rr, g0, g1;
  int gk[3];

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req0[d] = 0; req1[d] = 0; we0[d] = 0; we1[d] = 0;
      addr0[d] = 0; addr1[d] = 0; wdata0[d] = 0; wdata1[d] = 0;
      be0[d] = 0; be1[d] = 0;
      for (int i = 0; i < 64; i++) begin
        bmem[d][i] = 32'hA500_0000 | 32'(i);
        mmem[d][i] = 32'hA500_0000 | 32'(i);
      end
      bmem[d][8] = 32'h1234_5678;
      mmem[d][8] = 32'h1234_5678;
    end

    for (int d = 0; d < 2; d++) begin
      set_req(d, 0, 1'b1, 32'h30, 32'h1111_1111, 4'hF);
      set_req(d, 1, 1'b1, 32'h34, 32'h2222_2222, 4'hF);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rel_gnt0_early", d, gnt0[d], 0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rel_first_gnt0", d, gnt0[d], 1);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) drop(d, 0);
    fork
      wait_gnt(0, 1, g0);
      wait_gnt(1, 1, g1);
    join
    for (int d = 0; d < 2; d++) drop(d, 1);
    idle(2);

    for (int d = 0; d < 2; d++) begin
      txn(d, 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, n, g);
      drop(d, 0);
      chk("wr_gnt_lat", d, g - n, 1);
      @(negedge clk);
      chk("wr_busy_low", d, busy[d], 0);
      idle(2);

      txn(d, 1, 1'b0, 32'h20, 32'h0, 4'h0, n, g);
      drop(d, 1);
      wait_rv(d, 1, r);
      chk("rd_lat", d, r - n, rdl(d) + 2);
      chk("rd_data", d, rdata1[d], 32'h1234_5678);
      idle(2);

      glog.delete();
      fork
        agent(d, 0);
        agent(d, 1);
      join
      idle(12);
      chk("arb_count", d, glog.size(), 6);
      for (int k = 0; k < 6; k++) begin
        rr = (k < glog.size()) ? glog[k] : 2;
        chk("arb_order", d, rr, (d == 0) ? (k % 2) : ((k >= 3) ? 1 : 0));
      end

      txn(d, 0, 1'b0, 32'h24, 32'h0, 4'h0, n, g);
      drop(d, 0);
      set_req(d, 1, 1'b0, 32'h2C, 32'h0, 4'h0);
      @(posedge clk); #1;
      drop(d, 1);
      wait_rv(d, 0, r);
      chk("wd_rv_lat", d, r - n, rdl(d) + 2);
      chk("wd_data", d, rdata0[d], 32'hA500_0009);
      idle(4);

      txn(d, 0, 1'b0, 32'h28, 32'h0, 4'h0, n, g);
      drop(d, 0);
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(8);
      chk("abort_rdata0", d, rdata0[d], 0);

      for (int k = 0; k < 3; k++)
        txn(d, 0, 1'b1, 32'(4*k), wd_t[k], be_t[k], n, gk[k]);
      drop(d, 0);
      chk("b2b_gap1", d, gk[1] - gk[0], 2);
      chk("b2b_gap2", d, gk[2] - gk[1], 2);
      idle(2);
      txn(d, 0, 1'b0, 32'h8, 32'h0, 4'h0, n, g);
      drop(d, 0);
      wait_rv(d, 0, r);
      chk("rb_be5", d, rdata0[d], 32'hA533_0033);
      txn(d, 0, 1'b0, 32'h4, 32'h0, 4'h0, n, g);
      drop(d, 0);
      wait_rv(d, 0, r);
      chk("rb_be0", d, rdata0[d], 32'hA500_0001);
      idle(3);
    end

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory of the RV32 single-cycle datapath between two requesters.
- Requester 0 is the core load/store path; requester 1 is the program/data loader (debug/DMA).
- Serialises accesses, manages the memory's fixed read latency, and returns read data with a one-cycle valid pulse to the owning requester.
- Sits between the datapath's memory-access stage and the data memory.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width
RD_LAT, 1, memory read latency in cycles from mem_en to mem_rdata valid; legal range 1..4
FIXED_PRIO, 0, 0 = round-robin, 1 = requester 0 always wins

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req0 / req1  in  1  access request, held until matching gnt
we0 / we1  in  1  1 = write, 0 = read
addr0 / addr1  in  ADDR_W  byte address
wdata0 / wdata1  in  DATA_W  write data
be0 / be1  in  DATA_W/8  byte enables for writes
gnt0 / gnt1  out  1  one-cycle pulse: request accepted and issued to memory
rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid for that requester
rdata0 / rdata1  out  DATA_W  registered read data, held until next read response to same requester
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address, passed through unmodified
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 whenever state != IDLE
owner  out  1  index of the requester currently or most recently granted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output=0, including rdata0/1 and owner; last_owner=1, so requester 0 wins the first tie. Reset mid-access aborts the access immediately; no gnt or rvalid pulse follows deassertion.
- All outputs are registered; no combinational path from any input to any output.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only in this state. If no request, stay in IDLE. Otherwise pick the winner, latch its we/addr/wdata/be, and go to ISSUE.
- Arbitration with FIXED_PRIO=1: requester 0 wins whenever req0=1.
- Arbitration with FIXED_PRIO=0: a single requester wins outright; with both requesting, the requester != last_owner wins. last_owner and owner update on the grant.
- ISSUE (exactly one cycle): gnt<owner>=1, mem_en=1, and mem_we/mem_addr/mem_wdata/mem_be driven from the latched command. Next state is IDLE for a write and WAIT for a read.
- WAIT: a counter runs RD_LAT cycles after ISSUE. When mem_rdata is valid (RD_LAT cycles after the mem_en cycle), capture it into rdata<owner> and go to RESP.
- RESP (one cycle): rvalid<owner>=1; next state IDLE.
- Timing with the first request seen in IDLE at cycle N:
  - gnt and mem_en occur in cycle N+1.
  - A write completes at the end of N+1; the next IDLE is N+2.
  - A read's rvalid occurs in cycle N+2+RD_LAT.
- Requester rules:
  - A requester must hold req and its fields stable until gnt.
  - After gnt it may present a new request in the next cycle.
  - Dropping req before gnt silently withdraws the request.
- A latched command always completes, even if req drops afterwards.
- Writes with all be bits 0 are still issued (mem_en=1, mem_be=0); no rvalid is produced for writes.
- The other requester's req is ignored until state returns to IDLE; there are no queues and no overlap.
- Under continuous requests from both, round-robin grants strictly alternate (0,1,0,1,...), so neither requester starves.
- rdata0/1 hold their value across other traffic; only the matching rvalid updates them.

Test Plan:
- Reset: reset=0 for 3 cycles with req0=req1=1 → all outputs 0, busy=0; after release, first grant goes to requester 0 (gnt0 in the cycle after release+1).
- Single write: req0=1, we0=1, addr0=0x0000_0010, wdata0=0xDEAD_BEEF, be0=0xF → one cycle later gnt0=mem_en=mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; no rvalid0; busy low 2 cycles after request.
- Single read, RD_LAT=1 and RD_LAT=3: req1 read at 0x20, memory model returns 0x1234_5678 → rvalid1 pulses 3 (resp. 5) cycles after the request cycle, with rdata1=0x12345678.
- Round-robin contention: both hold read requests for 6 transactions → grant order 0,1,0,1,0,1 and each rvalid goes to the correct requester. Repeat with FIXED_PRIO=1 → requester 0 is granted every time while req0 held.
- Withdrawal and abort: req1 raised then dropped while a read for requester 0 is in WAIT → no gnt1. Then assert reset during WAIT → no rvalid0; rdata0 reads 0 after reset.
- Back-to-back writes from requester 0 (addr 0x0,0x4,0x8) → mem_en every 2nd cycle, addresses in order, be passed through (incl. be=0x0 case).
